// File: rtl/user_proj_pkg.sv
// user_proj_pkg: shared address map, memory geometry and engine state encoding
// for user_proj_example and its ann_engine.
package user_proj_pkg;

  // Address decode: the upper half-word selects a region
  localparam logic [31:0] REGION_MASK = 32'hFFFF_0000;
  localparam logic [31:0] CTRL_BASE   = 32'h3000_0000;
  localparam logic [31:0] QUERY_BASE  = 32'h3001_0000;
  localparam logic [31:0] LEAF_BASE   = 32'h3002_0000;
  localparam logic [31:0] BEST_BASE   = 32'h3003_0000;
  localparam logic [31:0] NODE_BASE   = 32'h3004_0000;

  // Control registers inside the control region
  localparam logic [31:0] MODE_ADDR   = 32'h3000_0000;
  localparam logic [31:0] DEBUG_ADDR  = 32'h3000_0004;
  localparam logic [31:0] DONE_ADDR   = 32'h3000_0008;
  localparam logic [31:0] START_ADDR  = 32'h3000_000C;
  localparam logic [31:0] BUSY_ADDR   = 32'h3000_0010;

  // Memory geometry (address widths, depths, data widths)
  localparam int QUERY_AW    = 12;
  localparam int QUERY_DEPTH = 4096;
  localparam int QUERY_DW    = 55;
  localparam int LEAF_AW     = 12;
  localparam int LEAF_DEPTH  = 4096;
  localparam int LEAF_DW     = 64;
  localparam int BEST_AW     = 9;
  localparam int BEST_DEPTH  = 512;
  localparam int BEST_DW     = 11;
  localparam int NODE_AW     = 6;
  localparam int NODE_DEPTH  = 64;
  localparam int NODE_DW     = 22;

  // Engine counter width; wide enough to also address the whole query memory
  localparam int CNT_W = 12;

  // Engine FSM encoding
  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_RUN  = 2'd1;
  localparam fsm_state_t ST_DONE = 2'd2;

  // Pick the 32-bit half of a 64-bit word addressed by adr[2]
  function automatic logic [31:0] half_select(input logic [63:0] word, input logic upper);
    logic [31:0] res;
    if (upper) begin
      res = word[63:32];
    end else begin
      res = word[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/ann_engine.sv
// ann_engine: copies the low 11 bits of query[i] into best[i] for
// i = 0..NUM_QUERYS-1, one entry per cycle. Owns the FSM, the entry counter
// and the best memory (engine write port, bus read port).
module ann_engine
  import user_proj_pkg::*;
#(
  parameter int NUM_QUERYS = 494
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [QUERY_AW-1:0] query_raddr,
  input  logic [BEST_DW-1:0]  query_key,
  input  logic [BEST_AW-1:0]  best_raddr,
  output logic [BEST_DW-1:0]  best_rdata,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_QUERYS);

  fsm_state_t          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                done_r;
  logic                wr_vld_r;
  logic [BEST_AW-1:0]  wr_idx_r;
  logic [BEST_DW-1:0]  wr_key_r;
  logic [BEST_DW-1:0]  best_mem [BEST_DEPTH];

  // The query entry being fetched is always the one the counter points at
  assign query_raddr = cnt_r[QUERY_AW-1:0];
  assign best_rdata  = best_mem[best_raddr];
  assign busy        = (state_r == ST_RUN);
  assign done        = done_r;
  assign count       = cnt_r;

  // FSM and counter; the write to best lags the fetch by one cycle, so the
  // FSM spends one extra RUN cycle draining it before raising done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      done_r   <= 1'b0;
      wr_vld_r <= 1'b0;
      wr_idx_r <= {BEST_AW{1'b0}};
      wr_key_r <= {BEST_DW{1'b0}};
    end else begin
      wr_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r <= ST_RUN;
            cnt_r   <= {CNT_W{1'b0}};
            done_r  <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          if (cnt_r < LAST_CNT) begin
            wr_vld_r <= 1'b1;
            wr_idx_r <= cnt_r[BEST_AW-1:0];
            wr_key_r <= query_key;
            cnt_r    <= cnt_r + CNT_W'(1);
          end else begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Best memory write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_vld_r) begin
      best_mem[wr_idx_r] <= wr_key_r;
    end
  end

endmodule

// File: rtl/user_proj_example.sv
// user_proj_example: Wishbone slave exposing control registers and the
// query / leaf / best / node memories, plus the ann_engine copy engine.
// Optional build macro: LA_DEBUG_EN drives engine status onto la_data_out.
module user_proj_example
  import user_proj_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int NUM_QUERYS = 494
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BITS-1:0] wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [BITS-1:0] wbs_dat_o,
  input  logic [127:0]    la_data_in,
  output logic [127:0]    la_data_out,
  input  logic [127:0]    la_oenb,
  input  logic [37:0]     io_in,
  output logic [37:0]     io_out,
  output logic [37:0]     io_oeb,
  output logic [2:0]      irq
);

  logic                 ack_r;
  logic [BITS-1:0]      dat_r;
  logic                 mode_r;
  logic                 debug_r;

  logic                 access_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [31:0]          region_s;
  logic                 start_s;
  logic [BITS-1:0]      rd_data_s;

  logic [QUERY_AW-1:0]  q_idx_s;
  logic [LEAF_AW-1:0]   l_idx_s;
  logic [BEST_AW-1:0]   b_idx_s;
  logic [NODE_AW-1:0]   n_idx_s;

  logic [QUERY_DW-1:0]  query_mem [QUERY_DEPTH];
  logic [LEAF_DW-1:0]   leaf_mem  [LEAF_DEPTH];
  logic [NODE_DW-1:0]   node_mem  [NODE_DEPTH];

  logic [QUERY_AW-1:0]  eng_raddr_s;
  logic [BEST_DW-1:0]   eng_key_s;
  logic [BEST_DW-1:0]   best_rd_s;
  logic                 busy_s;
  logic                 done_s;
  logic [CNT_W-1:0]     eng_cnt_s;
  logic                 unused_s;

  // A new access is accepted only when no ack is outstanding, so a held
  // strobe turns into one access every second cycle
  assign access_s = wbs_stb_i & wbs_cyc_i & ~ack_r;
  assign wr_en_s  = access_s & wbs_we_i;
  assign rd_en_s  = access_s & ~wbs_we_i;
  assign region_s = wbs_adr_i & REGION_MASK;
  assign start_s  = wr_en_s & (wbs_adr_i == START_ADDR);

  assign q_idx_s  = wbs_adr_i[14:3];
  assign l_idx_s  = wbs_adr_i[14:3];
  assign b_idx_s  = wbs_adr_i[11:3];
  assign n_idx_s  = wbs_adr_i[5:0];

  assign eng_key_s = query_mem[eng_raddr_s][BEST_DW-1:0];

  ann_engine #(
    .NUM_QUERYS (NUM_QUERYS)
  ) u_engine (
    .clk         (wb_clk_i),
    .rst_n       (wb_rst_i),
    .start       (start_s),
    .query_raddr (eng_raddr_s),
    .query_key   (eng_key_s),
    .best_raddr  (b_idx_s),
    .best_rdata  (best_rd_s),
    .busy        (busy_s),
    .done        (done_s),
    .count       (eng_cnt_s)
  );

  // Read-data selection for the access being accepted this cycle
  always_comb begin
    rd_data_s = {BITS{1'b0}};
    case (region_s)
      CTRL_BASE: begin
        case (wbs_adr_i)
          MODE_ADDR:  rd_data_s = {31'h0, mode_r};
          DEBUG_ADDR: rd_data_s = {31'h0, debug_r};
          DONE_ADDR:  rd_data_s = {31'h0, done_s};
          BUSY_ADDR:  rd_data_s = {31'h0, busy_s};
          default:    rd_data_s = {BITS{1'b0}};
        endcase
      end
      QUERY_BASE: rd_data_s = half_select({9'h0, query_mem[q_idx_s]}, wbs_adr_i[2]);
      LEAF_BASE:  rd_data_s = half_select(leaf_mem[l_idx_s], wbs_adr_i[2]);
      BEST_BASE:  rd_data_s = {21'h0, best_rd_s};
      NODE_BASE:  rd_data_s = {10'h0, node_mem[n_idx_s]};
      default:    rd_data_s = {BITS{1'b0}};
    endcase
  end

  // Wishbone handshake: one-cycle ack, read data registered alongside it
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_r <= 1'b0;
      dat_r <= {BITS{1'b0}};
    end else begin
      ack_r <= access_s;
      if (rd_en_s) begin
        dat_r <= rd_data_s;
      end else if (access_s) begin
        dat_r <= {BITS{1'b0}};
      end else begin
        dat_r <= dat_r;
      end
    end
  end

  // MODE and DEBUG control bits
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      mode_r  <= 1'b0;
      debug_r <= 1'b0;
    end else begin
      if (wr_en_s && (wbs_adr_i == MODE_ADDR)) begin
        mode_r <= wbs_dat_i[0];
      end else begin
        mode_r <= mode_r;
      end
      if (wr_en_s && (wbs_adr_i == DEBUG_ADDR)) begin
        debug_r <= wbs_dat_i[0];
      end else begin
        debug_r <= debug_r;
      end
    end
  end

  // Query memory bus writes; frozen while the engine is reading it
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_s && (region_s == QUERY_BASE) && !busy_s) begin
      if (wbs_adr_i[2]) begin
        query_mem[q_idx_s][54:32] <= wbs_dat_i[22:0];
      end else begin
        query_mem[q_idx_s][31:0] <= wbs_dat_i[31:0];
      end
    end
  end

  // Leaf memory bus writes, one 32-bit half per access
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_s && (region_s == LEAF_BASE)) begin
      if (wbs_adr_i[2]) begin
        leaf_mem[l_idx_s][63:32] <= wbs_dat_i[31:0];
      end else begin
        leaf_mem[l_idx_s][31:0] <= wbs_dat_i[31:0];
      end
    end
  end

  // Node memory bus writes: {median[21:11], index[10:0]}
  always_ff @(posedge wb_clk_i) begin
    if (wr_en_s && (region_s == NODE_BASE)) begin
      node_mem[n_idx_s] <= wbs_dat_i[NODE_DW-1:0];
    end
  end

  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;
  assign io_out    = {6'h00, done_s, busy_s, 30'h0000_0000};
  assign io_oeb    = {6'h3F, 2'b00, 30'h3FFF_FFFF};
  assign irq       = {2'b00, done_s};

`ifdef LA_DEBUG_EN
  assign la_data_out = {112'h0, eng_cnt_s, debug_r, mode_r, busy_s, done_s};
  assign unused_s    = ^{wbs_sel_i, la_data_in, la_oenb, io_in};
`else
  assign la_data_out = 128'h0;
  assign unused_s    = ^{wbs_sel_i, la_data_in, la_oenb, io_in, eng_cnt_s};
`endif

endmodule

// File: tb/tb_user_proj_example.sv
// tb_user_proj_example: randomized Wishbone traffic against a behavioural
// model of the memory map and copy engine; a monitor pops expected read data
// from a scoreboard queue on every ack.
module tb_user_proj_example;

  localparam int N = 494;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic         wbs_stb_i;
  logic         wbs_cyc_i;
  logic         wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_dat_i;
  logic [31:0]  wbs_adr_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] la_data_in;
  logic [127:0] la_data_out;
  logic [127:0] la_oenb;
  logic [37:0]  io_in;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;
  logic [2:0]   irq;

  user_proj_example #(.BITS(32), .NUM_QUERYS(N)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .la_data_in  (la_data_in),
    .la_data_out (la_data_out),
    .la_oenb     (la_oenb),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .irq         (irq)
  );

  // Reference model state
  logic [54:0] q_m [4096];
  logic [63:0] l_m [4096];
  logic [21:0] n_m [64];
  logic [10:0] b_m [512];
  logic        mode_m, debug_m, done_m, busy_m;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  logic [32:0] exp_q [$];
  logic [31:0] adr_q [$];
  logic [32:0] mon_e;
  logic [31:0] mon_a;

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Free-running cycle counter for latency measurement
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry; reads are compared
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack at cycle %0d", cyc_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = adr_q.pop_front();
        if (mon_e[32]) begin
          checks++;
          if (wbs_dat_o !== mon_e[31:0]) begin
            errors++;
            $display("FAIL read_%08h got %08h expected %08h", mon_a, wbs_dat_o, mon_e[31:0]);
          end
        end
      end
    end
  end

  task automatic acc(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [31:0] exp);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;
    exp_q.push_back({~we, exp});
    adr_q.push_back(adr);
    @(posedge wb_clk_i); #1;
    chk("ack_one_cycle", {63'h0, wbs_ack_o}, 64'h1);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    acc(1'b1, adr, dat, 32'h0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
    acc(1'b0, adr, 32'h0, exp);
  endtask

  function automatic logic [31:0] qa(input int idx, input logic hi);
    return 32'h3001_0000 + 32'(idx) * 32'd8 + (hi ? 32'd4 : 32'd0);
  endfunction

  function automatic logic [31:0] la_(input int idx, input logic hi);
    return 32'h3002_0000 + 32'(idx) * 32'd8 + (hi ? 32'd4 : 32'd0);
  endfunction

  function automatic logic [31:0] ba(input int idx, input logic hi);
    return 32'h3003_0000 + 32'(idx) * 32'd8 + (hi ? 32'd4 : 32'd0);
  endfunction

  // Engine semantics: after a run, best[i] = low 11 bits of query[i]
  task automatic model_run();
    for (int i = 0; i < N; i++) b_m[i] = q_m[i][10:0];
  endtask

  // Wait for done with a cycle budget and check the start-to-done latency
  task automatic wait_done(input int start_c, input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(posedge wb_clk_i); #1;
      if (io_out[31] === 1'b1) seen = 1'b1;
    end
    if (seen) chk(nm, 64'(cyc_cnt - start_c), 64'(N + 1));
    else      chk({nm, "_timeout"}, 64'h0, 64'h1);
  endtask

  task automatic chk_status(input string nm);
    chk({nm, "_io_out"}, 64'(io_out), 64'({6'h0, done_m, busy_m, 30'h0}));
    chk({nm, "_irq"}, 64'(irq), 64'({2'b00, done_m}));
  endtask

  initial begin
    int start_c, idx;
    logic [31:0] r;
    logic hi;
    int nidx [$];
    int lidx [$];
    logic lhi [$];

    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
    la_data_in = 128'h0; la_oenb = {128{1'b1}}; io_in = 38'h0;
    mode_m = 1'b0; debug_m = 1'b0; done_m = 1'b0; busy_m = 1'b0;
    wb_rst_i = 1'b1;
    #3 wb_rst_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_ack", {63'h0, wbs_ack_o}, 64'h0);
    chk("rst_dat", 64'(wbs_dat_o), 64'h0);
    chk_status("rst");
    chk("rst_io_oeb", 64'(io_oeb), 64'h3F_3FFF_FFFF);
    chk("rst_la", la_data_out[63:0], 64'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;

    // Control registers
    wr(32'h3000_0004, 32'h1); debug_m = 1'b1;
    wr(32'h3000_0000, 32'h1); mode_m = 1'b1;
    rd(32'h3000_0004, 32'h1);
    rd(32'h3000_0000, 32'h1);
    wr(32'h3000_0000, 32'hFFFF_FFFE); mode_m = 1'b0;
    rd(32'h3000_0000, {31'h0, mode_m});
    wr(32'h3000_0000, 32'h1); mode_m = 1'b1;

    // Node memory: fixed entry plus random ones
    wr(32'h3004_0005, 32'h0001_B801); n_m[5] = 22'h1_B801;
    rd(32'h3004_0005, 32'h0001_B801);
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(0, 63);
      r = $urandom;
      wr(32'h3004_0000 + 32'(idx), r);
      n_m[idx] = r[21:0];
      nidx.push_back(idx);
    end
    foreach (nidx[i]) rd(32'h3004_0000 + 32'(nidx[i]), {10'h0, n_m[nidx[i]]});

    // Leaf memory: fixed entry plus random halves
    wr(32'h3002_0018, 32'hDEAD_BEEF); l_m[3][31:0] = 32'hDEAD_BEEF;
    wr(32'h3002_001C, 32'h1234_5678); l_m[3][63:32] = 32'h1234_5678;
    rd(32'h3002_0018, 32'hDEAD_BEEF);
    rd(32'h3002_001C, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(4, 4095);
      hi = 1'($urandom_range(0, 1));
      r = $urandom;
      wr(la_(idx, hi), r);
      if (hi) l_m[idx][63:32] = r; else l_m[idx][31:0] = r;
      lidx.push_back(idx); lhi.push_back(hi);
    end
    foreach (lidx[i]) rd(la_(lidx[i], lhi[i]), lhi[i] ? l_m[lidx[i]][63:32] : l_m[lidx[i]][31:0]);

    // Query memory: query[i] = i + 100, a few random upper halves
    for (int i = 0; i < N; i++) begin
      wr(qa(i, 1'b0), 32'(i + 100));
      q_m[i][31:0] = 32'(i + 100);
    end
    for (int i = 0; i < 4; i++) begin
      idx = $urandom_range(0, N - 1);
      r = $urandom;
      wr(qa(idx, 1'b1), r);
      q_m[idx][54:32] = r[22:0];
      rd(qa(idx, 1'b1), {9'h0, q_m[idx][54:32]});
    end
    rd(qa(7, 1'b0), 32'd107);

    // Run 1 with a second start and an ignored query write mid-run
    model_run();
    wr(32'h3000_000C, 32'h1);
    start_c = cyc_cnt;
    busy_m = 1'b1; done_m = 1'b0;
    chk_status("run1_start");
    rd(32'h3000_0010, 32'h1);
    rd(32'h3000_0008, 32'h0);
    wr(qa(10, 1'b0), $urandom);
    wr(32'h3000_000C, 32'h1);
    wait_done(start_c, "run1_done_latency");
    busy_m = 1'b0; done_m = 1'b1;
    chk_status("run1_end");
`ifdef LA_DEBUG_EN
    chk("la_status", 64'(la_data_out[3:0]), 64'({debug_m, mode_m, busy_m, done_m}));
`else
    chk("la_zero", la_data_out[63:0] | la_data_out[127:64], 64'h0);
`endif

    rd(ba(7, 1'b0), 32'd107);
    rd(ba(7, 1'b1), 32'd107);
    rd(ba(0, 1'b0), {21'h0, b_m[0]});
    rd(ba(N - 1, 1'b1), {21'h0, b_m[N - 1]});
    rd(qa(10, 1'b0), 32'd110);
    wr(ba(7, 1'b0), 32'h0);
    rd(ba(7, 1'b0), 32'd107);
    rd(32'h3000_0008, 32'h1);
    wr(32'h3000_0008, 32'h0);
    rd(32'h3000_0008, 32'h1);
    rd(32'h3005_0000, 32'h0);
    rd(32'h3000_000C, 32'h0);
    rd(32'h3000_0014, 32'h0);

    // Run 2 from DONE with random keys
    for (int i = 0; i < N; i++) begin
      r = $urandom;
      wr(qa(i, 1'b0), r);
      q_m[i][31:0] = r;
    end
    model_run();
    wr(32'h3000_000C, 32'h1);
    start_c = cyc_cnt;
    busy_m = 1'b1; done_m = 1'b0;
    chk_status("run2_start");
    wait_done(start_c, "run2_done_latency");
    busy_m = 1'b0; done_m = 1'b1;
    chk_status("run2_end");
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(0, N - 1);
      hi = 1'($urandom_range(0, 1));
      rd(ba(idx, hi), {21'h0, b_m[idx]});
    end
    rd(ba(N - 1, 1'b0), {21'h0, b_m[N - 1]});

    // Reset in the middle of run 3
    wr(32'h3000_000C, 32'h1);
    repeat (100) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    busy_m = 1'b0; done_m = 1'b0; mode_m = 1'b0; debug_m = 1'b0;
    chk_status("midrun_rst");
    chk("midrun_rst_ack", {63'h0, wbs_ack_o}, 64'h0);
    chk("midrun_rst_dat", 64'(wbs_dat_o), 64'h0);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    rd(32'h3000_0000, 32'h0);
    rd(32'h3000_0004, 32'h0);
    rd(32'h3000_0008, 32'h0);
    rd(32'h3000_0010, 32'h0);
    chk_status("after_rst");

    repeat (2) @(posedge wb_clk_i);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_proj_example.md
USER_PROJ_EXAMPLE -- requirements
Module: user_proj_example

Interface
REQ-001 Parameter BITS, default 32: Wishbone data width; only 32 is supported.
REQ-002 Parameter NUM_QUERYS, default 494: number of best-array entries processed by the engine.
REQ-003 wb_clk_i  input  1: single clock for all logic.
REQ-004 wb_rst_i  input  1: asynchronous active-low reset (0 = reset).
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each: Wishbone strobe, cycle and write-enable.
REQ-006 wbs_sel_i  input  4: byte select; ignored, all accesses are full-word.
REQ-007 wbs_dat_i  input  32: write data.
REQ-008 wbs_adr_i  input  32: byte address.
REQ-009 wbs_ack_o  output  1: transfer acknowledge.
REQ-010 wbs_dat_o  output  32: read data.
REQ-011 la_data_in, la_oenb  input  128 each: unused; la_data_out  output  128: debug status.
REQ-012 io_in  input  38: unused; io_out  output  38: status pins; io_oeb  output  38: output enables (active-low).
REQ-013 irq  output  3: interrupts.

Function
REQ-014 Ack: wbs_ack_o is registered and driven to stb&cyc&~ack, giving a one-cycle pulse per access; a held strobe produces a new access every second cycle.
REQ-015 Region decode uses adr&0xFFFF_0000. Control registers are MODE 0x3000_0000 (bit0, R/W), DEBUG 0x3000_0004 (bit0, R/W), DONE 0x3000_0008 (bit0, RO), FSM_START 0x3000_000C (write only, pulses start) and FSM_BUSY 0x3000_0010 (bit0, RO).
REQ-016 Query memory at 0x3001_0000: 4096 x 55 bits; entry index = adr[14:3]; adr[2]=0 selects bits [31:0] and adr[2]=1 selects bits [54:32].
REQ-017 Leaf memory at 0x3002_0000: 4096 x 64 bits, indexed and half-selected the same way as the query memory.
REQ-018 Best memory at 0x3003_0000: 512 x 11 bits; index = adr[11:3]; read-only from the bus; reads return the value zero-extended in both halves.
REQ-019 Node memory at 0x3004_0000: 64 x 22 bits; index = adr[5:0]; a write stores dat_i[21:0] ({median[21:11], index[10:0]}).
REQ-020 Writes to read-only or unmapped addresses are ignored; reads of unmapped or write-only addresses return 0; unused read bits are 0.
REQ-021 Read data is registered and is valid in the same cycle as ack.
REQ-022 Engine FSM has states IDLE, RUN and DONE. A FSM_START write in IDLE or DONE enters RUN, clears done and zeroes the counter; a FSM_START write while in RUN is ignored.
REQ-023 In RUN, one entry per cycle: best[i] = query[i][10:0] for i = 0..NUM_QUERYS-1. After the last entry the FSM goes to DONE, so done rises NUM_QUERYS+1 cycles after the start ack.
REQ-024 busy = (state==RUN); done is sticky until the next start or reset.
REQ-025 Bus writes to the query memory during RUN are ignored; bus reads are always served.
REQ-026 io_out[31] = done, io_out[30] = busy, all other io_out bits = 0; io_oeb[31:30] = 0, all other io_oeb bits = 1.
REQ-027 irq[0] = done; irq[2:1] = 0.

Reset
REQ-028 While wb_rst_i=0: ack, dat_o, mode, debug, done, busy, counter and irq are 0 and the FSM is in IDLE; memory contents are undefined.
REQ-029 Reset asserted during RUN aborts the run immediately, leaving best partially written.

Configuration
REQ-030 With LA_DEBUG_EN defined, la_data_out[0]=done, [1]=busy, [2]=mode, [3]=debug, [15:4]=engine counter, and all other bits 0.
REQ-031 Without LA_DEBUG_EN, la_data_out is constant 0.

Structure
REQ-032 Package user_proj_pkg holds the address constants, the region mask, memory depths and widths, and the FSM state typedef.
REQ-033 One sub-module, ann_engine, contains the FSM, the counter and the best-memory write port.

Verification
REQ-034 Reset then write 1 to DEBUG and 1 to MODE -> each access acks in one cycle; reading DEBUG and MODE returns 0x1.
REQ-035 Write node index 5 with 0x0001_B801 -> the node entry holds 0x1B801 (median 55, index 1).
REQ-036 Write leaf entry 3 lower half 0xDEAD_BEEF and upper half 0x1234_5678 -> reads of 0x3002_0018 and 0x3002_001C return the same values.
REQ-037 Load query[i] = i+100 for all i, then write FSM_START -> busy=1; io_out[31] rises 495 cycles later; reading best entry 7 returns 107.
REQ-038 Write FSM_START again during RUN -> ignored and done timing unchanged; pull reset low mid-run -> busy=0 and done=0 immediately.
REQ-039 Read 0x3005_0000 -> returns 0 with ack; write to DONE -> DONE register unchanged.
